// File: rtl/power_up_if.sv
// Spawn/collect handshake between the LFSR spawner, player logic and the power-up manager.
interface power_up_if #(
  parameter int NUM_TYPES = 4,
  parameter int TYPE_W    = 2
);
  logic                 generate_powerup;
  logic [TYPE_W-1:0]    lfsr_type;
  logic                 collected;
  logic                 pending_valid;
  logic [TYPE_W-1:0]    pending_type;
  logic [NUM_TYPES-1:0] effect_active;
  logic [NUM_TYPES-1:0] effect_pulse;
  logic [3:0]           powerup_red;
  logic [3:0]           powerup_green;
  logic [3:0]           powerup_blue;

  modport master (
    output generate_powerup, lfsr_type, collected,
    input  pending_valid, pending_type, effect_active, effect_pulse,
           powerup_red, powerup_green, powerup_blue
  );

  modport slave (
    input  generate_powerup, lfsr_type, collected,
    output pending_valid, pending_type, effect_active, effect_pulse,
           powerup_red, powerup_green, powerup_blue
  );
endinterface

// File: rtl/power_up_manager.sv
// One-at-a-time power-up spawner: pending/cooldown FSM plus one effect lane per type
// (frame countdown for timed types, single-frame pulse for instant types).
module pu_lane #(
  parameter bit INSTANT  = 1'b0,
  parameter int TIMER_W  = 10,
  parameter int DURATION = 600
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic hit,
  output logic active,
  output logic pulse
);
  if (INSTANT) begin : g_inst
    always_ff @(posedge frame_clk or posedge Reset)
      if (Reset) pulse <= 1'b0;
      else       pulse <= hit;
    assign active = 1'b0;
  end else begin : g_timed
    logic [TIMER_W-1:0] eff_ctr;
    // A fresh collection reloads the full duration, even mid-countdown.
    always_ff @(posedge frame_clk or posedge Reset)
      if (Reset)               eff_ctr <= '0;
      else if (hit)            eff_ctr <= TIMER_W'(DURATION);
      else if (eff_ctr != '0)  eff_ctr <= eff_ctr - 1'b1;
    assign active = (eff_ctr != '0);
    assign pulse  = 1'b0;
  end
endmodule

module power_up_manager #(
  parameter int                      NUM_TYPES    = 4,
  parameter int                      TYPE_W       = 2,
  parameter logic [NUM_TYPES-1:0]    INSTANT_MASK = 4'b0010,
  parameter int                      DURATION     = 600,
  parameter int                      LIFETIME     = 300,
  parameter int                      COOLDOWN     = 120,
  parameter int                      TIMER_W      = 10,
  parameter logic [12*NUM_TYPES-1:0] PALETTE      = {12'hFF0, 12'h0F0, 12'hFFF, 12'h00F}
) (
  input logic      frame_clk,
  input logic      Reset,
  power_up_if.slave pu
);
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COOLDOWN} state_t;

  localparam logic [TYPE_W:0]    NT      = (TYPE_W+1)'(NUM_TYPES);
  localparam logic [TIMER_W-1:0] LIFE_T  = TIMER_W'(LIFETIME);
  localparam logic [TIMER_W-1:0] COOL_T  = TIMER_W'(COOLDOWN);
  localparam logic [TIMER_W-1:0] ONE_T   = TIMER_W'(1);

  state_t             state, state_nx;
  logic [TIMER_W-1:0] life_ctr, life_nx, cd_ctr, cd_nx;
  logic [TYPE_W-1:0]  type_q, type_nx;
  logic               apply;
  logic [11:0]        rgb_nx;
  logic [11:0]        rgb_q;
  logic               pend_q;
  logic [TYPE_W-1:0]  pend_type_q;
  logic [NUM_TYPES-1:0] hit;

  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state    <= S_IDLE;
      life_ctr <= '0;
      cd_ctr   <= '0;
      type_q   <= '0;
    end else begin
      state    <= state_nx;
      life_ctr <= life_nx;
      cd_ctr   <= cd_nx;
      type_q   <= type_nx;
    end

  always_comb begin
    state_nx = state;
    life_nx  = life_ctr;
    cd_nx    = cd_ctr;
    type_nx  = type_q;
    apply    = 1'b0;
    unique case (state)
      S_IDLE:
        if (pu.generate_powerup && ({1'b0, pu.lfsr_type} < NT)) begin
          state_nx = S_PENDING;
          type_nx  = pu.lfsr_type;
          life_nx  = LIFE_T;
        end
      S_PENDING:
        // Collection is checked first so a last-frame grab still earns the effect.
        if (pu.collected) begin
          state_nx = S_COOLDOWN;
          apply    = 1'b1;
          cd_nx    = COOL_T;
        end else if (life_ctr <= ONE_T) begin
          state_nx = S_COOLDOWN;
          cd_nx    = COOL_T;
        end else begin
          life_nx  = life_ctr - 1'b1;
        end
      S_COOLDOWN:
        if (cd_ctr <= ONE_T) state_nx = S_IDLE;
        else                 cd_nx    = cd_ctr - 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rgb_nx = '0;
    for (int i = 0; i < NUM_TYPES; i++)
      if (type_nx == TYPE_W'(i)) rgb_nx = PALETTE[12*i +: 12];
  end

  // Outputs are flopped from next-state so they line up with the state register.
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      pend_q      <= 1'b0;
      pend_type_q <= '0;
      rgb_q       <= '0;
    end else begin
      pend_q      <= (state_nx == S_PENDING);
      pend_type_q <= (state_nx == S_PENDING) ? type_nx : '0;
      rgb_q       <= (state_nx == S_PENDING) ? rgb_nx  : '0;
    end

  for (genvar g = 0; g < NUM_TYPES; g++) begin : g_lane
    assign hit[g] = apply && (type_q == TYPE_W'(g));
    pu_lane #(
      .INSTANT (INSTANT_MASK[g]),
      .TIMER_W (TIMER_W),
      .DURATION(DURATION)
    ) u_lane (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .hit      (hit[g]),
      .active   (pu.effect_active[g]),
      .pulse    (pu.effect_pulse[g])
    );
  end

  assign pu.pending_valid = pend_q;
  assign pu.pending_type  = pend_type_q;
  assign pu.powerup_red   = rgb_q[11:8];
  assign pu.powerup_green = rgb_q[7:4];
  assign pu.powerup_blue  = rgb_q[3:0];
endmodule

// File: tb/tb_power_up_manager.sv
// Directed bench for power_up_manager: frame-level model compared every cycle,
// plus hand-computed frame counts and colours for each scenario.
module tb_power_up_manager;
  localparam int DUR  = 5;
  localparam int LIFE = 4;
  localparam int COOL = 3;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  power_up_if #(.NUM_TYPES(4), .TYPE_W(2)) pu_if ();

  power_up_manager #(
    .DURATION(DUR), .LIFETIME(LIFE), .COOLDOWN(COOL)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .pu       (pu_if.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: frames left on screen, frames of cooldown left, frames of effect left.
  int       m_pend = 0;
  int       m_cool = 0;
  bit       m_cooling = 0;
  int       m_type = 0;
  int       m_eff[4] = '{0, 0, 0, 0};
  bit [3:0] m_pulse = '0;
  bit [3:0] IMASK = 4'b0010;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_pend = 0; m_cool = 0; m_cooling = 0; m_type = 0; m_pulse = '0;
      for (int i = 0; i < 4; i++) m_eff[i] = 0;
    end else begin
      m_pulse = '0;
      for (int i = 0; i < 4; i++) if (m_eff[i] > 0) m_eff[i] = m_eff[i] - 1;
      if (m_pend > 0) begin
        if (pu_if.collected) begin
          if (IMASK[m_type]) m_pulse[m_type] = 1'b1;
          else               m_eff[m_type] = DUR;
          m_pend = 0; m_cooling = 1; m_cool = COOL;
        end else begin
          m_pend = m_pend - 1;
          if (m_pend == 0) begin m_cooling = 1; m_cool = COOL; end
        end
      end else if (m_cooling) begin
        if (m_cool <= 1) m_cooling = 0;
        else             m_cool = m_cool - 1;
      end else if (pu_if.generate_powerup && pu_if.lfsr_type < 4) begin
        m_pend = LIFE;
        m_type = int'(pu_if.lfsr_type);
      end
    end
  end

  function automatic logic [11:0] colour_of(input int t);
    case (t)
      0: return 12'h00F;
      1: return 12'hFFF;
      2: return 12'h0F0;
      default: return 12'hFF0;
    endcase
  endfunction

  always @(negedge frame_clk) begin
    logic [3:0]  exp_act;
    logic [11:0] exp_rgb;
    exp_act = '0;
    for (int i = 0; i < 4; i++) exp_act[i] = (m_eff[i] > 0);
    exp_rgb = (m_pend > 0) ? colour_of(m_type) : 12'h000;
    chk("pending_valid", pu_if.pending_valid, (m_pend > 0));
    chk("effect_active", pu_if.effect_active, exp_act);
    chk("effect_pulse",  pu_if.effect_pulse,  m_pulse);
    chk("colour", {pu_if.powerup_red, pu_if.powerup_green, pu_if.powerup_blue}, exp_rgb);
    if (m_pend > 0) chk("pending_type", pu_if.pending_type, m_type);
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    int n;
    int run;
    bit alive;
    pu_if.generate_powerup = 1'b0;
    pu_if.lfsr_type        = '0;
    pu_if.collected        = 1'b0;
    #2;
    chk("rst_pv",    pu_if.pending_valid, 0);
    chk("rst_act",   pu_if.effect_active, 0);
    chk("rst_pulse", pu_if.effect_pulse, 0);
    chk("rst_rgb",   {pu_if.powerup_red, pu_if.powerup_green, pu_if.powerup_blue}, 0);
    #11 Reset = 1'b0;
    tick();

    // Timed type 3, collected in its second on-screen frame.
    pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd3;
    tick();
    pu_if.generate_powerup = 1'b0;
    chk("A_pv", pu_if.pending_valid, 1);
    chk("A_type", pu_if.pending_type, 3);
    chk("A_red", pu_if.powerup_red, 4'hF);
    chk("A_green", pu_if.powerup_green, 4'hF);
    chk("A_blue", pu_if.powerup_blue, 4'h0);
    tick();
    pu_if.collected = 1'b1;
    tick();
    pu_if.collected = 1'b0;
    chk("A_pv_after", pu_if.pending_valid, 0);
    chk("A_red_after", pu_if.powerup_red, 0);
    n = 0;
    while (pu_if.effect_active[3] && n < 20) begin n++; tick(); end
    chk("A_active_frames", n, 5);
    repeat (6) tick();

    // Instant type 1.
    pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd1;
    tick();
    pu_if.generate_powerup = 1'b0; pu_if.collected = 1'b1;
    tick();
    pu_if.collected = 1'b0;
    chk("B_pulse", pu_if.effect_pulse, 4'b0010);
    chk("B_active", pu_if.effect_active, 0);
    tick();
    chk("B_pulse_gone", pu_if.effect_pulse, 0);
    repeat (5) tick();

    // Never collected; request held high through expiry and cooldown.
    pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd2;
    tick();
    n = 0;
    while (pu_if.pending_valid && n < 20) begin n++; tick(); end
    chk("C_pending_frames", n, 4);
    chk("C_no_effect", pu_if.effect_active, 0);
    chk("C_no_pulse", pu_if.effect_pulse, 0);
    n = 0;
    while (!pu_if.pending_valid && n < 20) begin n++; tick(); end
    chk("C_gap_frames", n, 4);
    pu_if.generate_powerup = 1'b0;
    repeat (10) tick();

    // Type 0 collected in the same frame it would expire.
    pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd0;
    tick();
    pu_if.generate_powerup = 1'b0;
    repeat (3) tick();
    chk("D_last_frame_pv", pu_if.pending_valid, 1);
    pu_if.collected = 1'b1;
    tick();
    pu_if.collected = 1'b0;
    chk("D_active", pu_if.effect_active[0], 1);
    chk("D_pv", pu_if.pending_valid, 0);

    // Re-collect type 0 while its effect still runs: reload keeps it unbroken.
    run = 0; alive = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (alive && pu_if.effect_active[0]) run++; else alive = 1'b0;
      if (k == 0) begin pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd0; end
      if (k == 4) begin
        chk("E_respawn_pv", pu_if.pending_valid, 1);
        pu_if.generate_powerup = 1'b0; pu_if.collected = 1'b1;
      end
      if (k == 5) pu_if.collected = 1'b0;
      tick();
    end
    chk("E_active_run", run, 10);
    repeat (4) tick();

    // Reset in the middle of a frame while an effect is active.
    pu_if.generate_powerup = 1'b1; pu_if.lfsr_type = 2'd3;
    tick();
    pu_if.generate_powerup = 1'b0; pu_if.collected = 1'b1;
    tick();
    pu_if.collected = 1'b0;
    chk("R_pre_active", pu_if.effect_active[3], 1);
    #2 Reset = 1'b1;
    #1;
    chk("R_pv",  pu_if.pending_valid, 0);
    chk("R_act", pu_if.effect_active, 0);
    chk("R_pulse", pu_if.effect_pulse, 0);
    chk("R_rgb", {pu_if.powerup_red, pu_if.powerup_green, pu_if.powerup_blue}, 0);
    #3 Reset = 1'b0;
    tick();
    chk("R_after_act", pu_if.effect_active, 0);
    chk("R_after_pv", pu_if.pending_valid, 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
